// File: rtl/x_uart_pkg.sv
// x_uart_pkg: shared definitions for the x_uart receiver and transmitter.
//   x_uart_rx_state_t : receiver FSM states (PARITY only with X_UART_RX_PARITY_EN)
//   baud_period()     : T = ceil(clk_hz / baud), clocks per bit
//   baud_half()       : H = T/2, mid-bit sample offset
//   baud_timer_w()    : width of the 0..T-1 bit timer
package x_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef X_UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } x_uart_rx_state_t;

    // Ceiling done by hand: truncate, then bump if anything was cut off.
    function automatic int baud_period(input real clk_hz, input real baud);
        real r;
        int  t;
        r = clk_hz / baud;
        t = $rtoi(r);
        if ($itor(t) < r) t = t + 1;
        return t;
    endfunction

    function automatic int baud_half(input real clk_hz, input real baud);
        return baud_period(clk_hz, baud) / 2;
    endfunction

    function automatic int baud_timer_w(input real clk_hz, input real baud);
        return $clog2(baud_period(clk_hz, baud));
    endfunction

endpackage

// File: rtl/x_uart_sync3.sv
// x_uart_sync3: three-flop synchroniser for the serial line.
//   clk, rst : clock, synchronous active-high reset (flops reset to 1 = idle line)
//   din      : asynchronous serial input
//   fall     : falling edge seen between stages 2 and 3
//   maj      : majority vote of the three stages
module x_uart_sync3 (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic fall,
    output logic maj
);

    logic p1, p2, p3;

    always_ff @(posedge clk) begin
        if (rst) begin
            p1 <= 1'b1;
            p2 <= 1'b1;
            p3 <= 1'b1;
        end else begin
            p1 <= din;
            p2 <= p1;
            p3 <= p2;
        end
    end

    assign fall = ~p2 & p3;
    assign maj  = (p1 & p2) | (p1 & p3) | (p2 & p3);

endmodule

// File: rtl/x_uart_rx_param.sv
// x_uart_rx_param: parametrised UART receiver with majority sampling,
// false-start rejection, framing check, optional parity (X_UART_RX_PARITY_EN)
// and a valid/ready output holding register with overrun reporting.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_rx         : asynchronous serial line, idle high
//   i_ready      : consumer takes the held word this cycle
//   o_valid      : held word available
//   o_data       : received word, LSB = first data bit on the line
//   o_frame_err  : a stop bit of the held word was sampled low
//   o_par_err    : parity mismatch of the held word (0 without parity build)
//   o_overrun    : one-cycle pulse when a completed frame is dropped
module x_uart_rx_param
    import x_uart_pkg::*;
#(
    parameter real p_clk_hz     = 1000000.0,
    parameter real p_baud       = 115200.0,
    parameter int  p_data_bits  = 8,
    parameter int  p_stop_bits  = 1,
    parameter bit  p_parity_odd = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rx,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [p_data_bits-1:0] o_data,
    output logic                   o_frame_err,
    output logic                   o_par_err,
    output logic                   o_overrun
);

    localparam int T  = baud_period(p_clk_hz, p_baud);
    localparam int H  = baud_half(p_clk_hz, p_baud);
    localparam int TW = baud_timer_w(p_clk_hz, p_baud);
    localparam int BW = $clog2(p_data_bits);

    localparam logic [TW-1:0] T_LAST    = TW'(T - 1);
    localparam logic [TW-1:0] H_CNT     = TW'(H);
    localparam logic [BW-1:0] BIT_LAST  = BW'(p_data_bits - 1);
    localparam logic          STOP_LAST = 1'(p_stop_bits - 1);

    logic fall, sample;

    x_uart_sync3 u_sync (
        .clk  (i_clk),
        .rst  (i_rst),
        .din  (i_rx),
        .fall (fall),
        .maj  (sample)
    );

    x_uart_rx_state_t       state;
    logic [TW-1:0]          timer;
    logic [BW-1:0]          bit_cnt;
    logic                   stop_idx;
    logic [p_data_bits-1:0] shreg;
    logic                   ferr_acc;

    logic at_mid, at_wrap, complete, frame_err_now;

    assign at_mid        = (timer == H_CNT);
    assign at_wrap       = (timer == T_LAST);
    // Frame ends at the mid-point of the last stop bit, not its end, so a
    // start edge arriving right at the stop-bit boundary is still seen.
    assign complete      = (state == ST_STOP) && at_mid && (stop_idx == STOP_LAST);
    assign frame_err_now = ferr_acc | ~sample;

`ifdef X_UART_RX_PARITY_EN
    logic perr;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            ferr_acc <= 1'b0;
`ifdef X_UART_RX_PARITY_EN
            perr     <= 1'b0;
`endif
        end else begin
            timer <= (state == ST_IDLE || at_wrap) ? '0 : timer + 1'b1;
            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        state    <= ST_START;
                        bit_cnt  <= '0;
                        stop_idx <= 1'b0;
                        ferr_acc <= 1'b0;
                    end
                end
                ST_START: begin
                    // Line back high at mid start bit: glitch, not a frame.
                    if (at_mid && sample) begin
                        state <= ST_IDLE;
                        timer <= '0;
                    end else if (at_wrap) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (at_mid) shreg <= {sample, shreg[p_data_bits-1:1]};
                    if (at_wrap) begin
                        if (bit_cnt == BIT_LAST) begin
`ifdef X_UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef X_UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (at_mid) perr <= ((^shreg) ^ sample) != p_parity_odd;
                    if (at_wrap) state <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    if (at_mid) begin
                        ferr_acc <= frame_err_now;
                        if (stop_idx == STOP_LAST) begin
                            state <= ST_IDLE;
                            timer <= '0;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Holding register: a new frame only overwrites a word the consumer has
    // already taken (or is taking this very cycle).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
`ifdef X_UART_RX_PARITY_EN
            o_par_err   <= 1'b0;
`endif
        end else begin
            o_overrun <= 1'b0;
            if (complete) begin
                if (~o_valid | i_ready) begin
                    o_valid     <= 1'b1;
                    o_data      <= shreg;
                    o_frame_err <= frame_err_now;
`ifdef X_UART_RX_PARITY_EN
                    o_par_err   <= perr;
`endif
                end else begin
                    o_overrun <= 1'b1;
                end
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

`ifndef X_UART_RX_PARITY_EN
    assign o_par_err = 1'b0;
`endif

endmodule

// File: tb/tb_x_uart_rx_param.sv
`timescale 1ns/1ps
module tb_x_uart_rx_param;

`ifdef X_UART_RX_PARITY_EN
    localparam int DB  = 7;
    localparam int SB  = 2;
    localparam bit ODD = 1'b1;
    localparam bit PAR = 1'b1;
`else
    localparam int DB  = 8;
    localparam int SB  = 1;
    localparam bit ODD = 1'b0;
    localparam bit PAR = 1'b0;
`endif
    localparam int T = 9;   // ceil(1e6 / 115200)
    localparam int H = 4;

    typedef struct {
        logic [DB-1:0] data;
        logic          ferr;
        logic          perr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          ready = 1'b1;
    logic          valid;
    logic [DB-1:0] data;
    logic          frame_err, par_err, overrun;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   ovr_seen = 0;
    int   ovr_exp = 0;
    bit   mon_en = 1'b0;

    always #5 clk = ~clk;

    x_uart_rx_param #(
        .p_clk_hz    (1000000.0),
        .p_baud      (115200.0),
        .p_data_bits (DB),
        .p_stop_bits (SB),
        .p_parity_odd(ODD)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rx       (rx),
        .i_ready    (ready),
        .o_valid    (valid),
        .o_data     (data),
        .o_frame_err(frame_err),
        .o_par_err  (par_err),
        .o_overrun  (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_valid"},   32'(valid), 32'd0);
        chk({tag, "_data"},    32'(data), 32'd0);
        chk({tag, "_ferr"},    32'(frame_err), 32'd0);
        chk({tag, "_perr"},    32'(par_err), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    endtask

    // Monitor: looks just after each falling edge, i.e. at the values that the
    // next rising edge will act on.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                if (overrun) ovr_seen++;
                if (valid) begin
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL spurious_valid: got data %0h with nothing expected at %0t", data, $time);
                    end else begin
                        chk("word_data", 32'(data), 32'(q[0].data));
                        chk("word_ferr", 32'(frame_err), 32'(q[0].ferr));
                        chk("word_perr", 32'(par_err), 32'(q[0].perr));
                        if (ready) void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (T) @(negedge clk);
    endtask

    // Frame on the line; the expectation is queued before the first bit so the
    // monitor always finds it in time.
    task automatic send_frame(input logic [DB-1:0] d, input bit bad_stop,
                              input bit bad_par, input bit expect_load);
        exp_t e;
        e.data = d;
        e.ferr = bad_stop;
        e.perr = PAR & bad_par;
        if (expect_load) q.push_back(e);
        else ovr_exp++;
        send_bit(1'b0);
        for (int i = 0; i < DB; i++) send_bit(d[i]);
        if (PAR) send_bit((^d) ^ ODD ^ bad_par);
        for (int s = 0; s < SB; s++) send_bit(!(bad_stop && s == SB - 1));
        rx = 1'b1;
        repeat (2 * T) @(negedge clk);
    endtask

    initial begin
        logic [DB-1:0] d;
        int            budget;

        repeat (4) @(negedge clk);
        #1;
        chk_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3 * T) @(negedge clk);
        #1;
        chk_outputs_zero("post_reset");
        mon_en = 1'b1;

        send_frame(DB'(8'hA5), 1'b0, 1'b0, 1'b1);

        // Short low glitch must be rejected at mid start bit.
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * T) @(negedge clk);

        send_frame(DB'(8'h3C), 1'b1, 1'b0, 1'b1);

        // Consumer stalled: second frame is dropped, first word held.
        ready = 1'b0;
        send_frame(DB'(8'h11), 1'b0, 1'b0, 1'b1);
        send_frame(DB'(8'h22), 1'b0, 1'b0, 1'b0);
        repeat (3 * T) @(negedge clk);
        ready = 1'b1;
        repeat (4) @(negedge clk);
        chk("overrun_count_stall", 32'(ovr_seen), 32'(ovr_exp));

        // Reset during data bit 3 while a word is being held.
        ready = 1'b0;
        send_frame(DB'(8'h5A), 1'b0, 1'b0, 1'b1);
        d = DB'(8'h0F);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        rx = d[3];
        repeat (H) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx = 1'b1;
        q.delete();
        #1;
        chk_outputs_zero("mid_reset");
        ready = 1'b1;
        repeat (3 * T) @(negedge clk);
        send_frame(DB'(8'h81), 1'b0, 1'b0, 1'b1);

        // Parity good / flipped (flags stay 0 in the plain build).
        send_frame(DB'(8'h55), 1'b0, 1'b0, 1'b1);
        send_frame(DB'(8'h55), 1'b0, 1'b1, 1'b1);

        for (int n = 0; n < 24; n++) begin
            send_frame(DB'($urandom), $urandom_range(0, 7) == 0,
                       $urandom_range(0, 3) == 0, 1'b1);
        end

        budget = 20 * T;
        while (q.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("overrun_count_final", 32'(ovr_seen), 32'(ovr_exp));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/x_uart_rx_param.md
# x_uart_rx_param

Parametrised UART receiver, successor to the fixed 8N1 receiver: configurable data width and stop-bit count, three-sample majority voting, false-start rejection, stop-bit framing check, optional parity, and a valid/ready output register with overrun reporting. It sits between the asynchronous serial pin and a streaming consumer (FIFO or command decoder) in the `i_clk` domain.

## Interface
- `p_clk_hz`, 1000000, system clock frequency (real)
- `p_baud`, 115200, line baud rate (real)
- `p_data_bits`, 8, data bits per frame, legal 5..9
- `p_stop_bits`, 1, stop bits per frame, legal 1..2
- `p_parity_odd`, 0, 1 = odd, 0 = even parity; used only when parity is compiled in
- `i_clk`  in  1  clock; one clock domain
- `i_rst`  in  1  reset, synchronous, active-high
- `i_rx`  in  1  asynchronous serial line, idle high
- `i_ready`  in  1  consumer accepts held word this cycle
- `o_valid`  out  1  held word available
- `o_data`  out  p_data_bits  received word, LSB = first bit on the line
- `o_frame_err`  out  1  stop bit sampled low for the held word
- `o_par_err`  out  1  parity mismatch for the held word; tied 0 when parity is compiled out
- `o_overrun`  out  1  one-cycle pulse: a completed frame was dropped

## Operation
- Input synchroniser: three flops `p1`→`p2`→`p3`, all reset to 1. Falling edge = `~p2 & p3`. Sample value = majority(`p1`,`p2`,`p3`).
- Bit period `T = ceil(p_clk_hz/p_baud)`; `H = T/2` (integer). Timer width `$clog2(T)`; counts 0..T-1 then wraps to 0.
- States: IDLE, START, DATA, PARITY (parity build only), STOP.
- IDLE: on falling edge → START, timer := 0, bit counter := 0.
- START: at timer == H, if sample is 1 → IDLE (false start, no output, no flags); else continue; at wrap → DATA.
- DATA: at timer == H shift sample into MSB of a `p_data_bits` shift register (LSB-first line order); at wrap increment bit counter; after bit `p_data_bits-1` wrap → PARITY or STOP.
- PARITY: at timer == H capture parity error = XOR(data, sample) ≠ `p_parity_odd`; at wrap → STOP.
- STOP: at timer == H sample stop bit; a 0 on any stop bit sets frame error. With `p_stop_bits`=2, wait for wrap then sample second stop at H. Frame completes at the last stop-bit sample point; state → IDLE the next cycle, so a start edge at the stop-bit end is caught.
- Frame errors do not suppress the word; it is delivered with `o_frame_err`=1.
- Output register: on completion, if `~o_valid | i_ready`, load data and flags, `o_valid`:=1. Else drop the new frame, keep held word, pulse `o_overrun`.
- `o_valid & i_ready` with no completion that cycle → `o_valid`:=0. Completion and accept in the same cycle → new word loaded, `o_valid` stays 1, no overrun.

## Timing
- Reset: all outputs 0, `o_data`=0, state IDLE, timer 0, synchroniser flops 1. Reset mid-frame aborts the frame with no output.
- `i_rx` falling edge → falling-edge detect 2 cycles later → START the next cycle.
- Completion → `o_valid` high the next cycle.
- `o_data`/flags stable while `o_valid & ~i_ready`.
- `o_overrun` high for exactly 1 cycle per dropped frame.
- Tolerance: sample at mid-bit ±1 cycle from the majority window; requires T ≥ 4.

## Configuration
- `X_UART_RX_PARITY_EN` defined: PARITY state present; frame = start + data + parity + stop(s); `o_par_err` valid per word.
- Undefined: no PARITY state or parity logic; frame = start + data + stop(s); `o_par_err` tied 0; `p_parity_odd` ignored.

## Structure
- Shared package `x_uart_pkg`: state enum `x_uart_rx_state_t`, and the baud-timer constant functions (T, H, width) shared with the TX side.
- One sub-module `x_uart_sync3`: 3-flop synchroniser with reset-to-1, edge detect, and majority output.

## Test plan
Parameters: p_clk_hz=1e6, p_baud=115200 (T=9, H=4), 8N1 unless stated.
- Send 0xA5, `i_ready`=1 → one `o_valid` pulse, `o_data`=0xA5, all flags 0.
- 3-cycle low glitch on idle line → START aborts at H, no `o_valid`, state returns to IDLE.
- 0x3C with stop bit forced low → `o_data`=0x3C, `o_frame_err`=1.
- Hold `i_ready`=0, send 0x11 then 0x22 → `o_data` stays 0x11, one `o_overrun` pulse; then `i_ready`=1 → `o_valid` drops.
- `p_data_bits`=7, `p_stop_bits`=2, parity build, `p_parity_odd`=1: 0x55 with correct parity → `o_par_err`=0; flipped parity bit → `o_par_err`=1.
- Assert `i_rst` during DATA bit 3 → outputs 0 next cycle; following 0x81 frame received correctly.
